// File: rtl/control_sequencer_if.sv
// Bus-side and control-strobe bundle for the SAP control sequencer.
// The master modport is the sequencer. The slave modport is the datapath/RAM side that consumes its strobes.
interface control_sequencer_if;
  logic       prog_mode;
  logic [7:0] bus_in;
  logic [3:0] operand_out;
  logic [3:0] opcode;
  logic [2:0] step;
  logic       hlt;
  logic       pc_out_n;
  logic       pc_inc;
  logic       pc_jump_n;
  logic       mar_in_n;
  logic       ram_out_n;
  logic       ram_in;
  logic       ir_in_n;
  logic       ir_out_n;
  logic       a_in_n;
  logic       a_out_n;
  logic       b_in_n;
  logic       alu_out_n;
  logic       alu_sub;
  logic       out_in_n;

  modport master (
    input  prog_mode, bus_in,
    output operand_out, opcode, step, hlt,
    output pc_out_n, pc_inc, pc_jump_n, mar_in_n, ram_out_n, ram_in,
    output ir_in_n, ir_out_n, a_in_n, a_out_n, b_in_n, alu_out_n, alu_sub, out_in_n
  );

  modport slave (
    output prog_mode, bus_in,
    input  operand_out, opcode, step, hlt,
    input  pc_out_n, pc_inc, pc_jump_n, mar_in_n, ram_out_n, ram_in,
    input  ir_in_n, ir_out_n, a_in_n, a_out_n, b_in_n, alu_out_n, alu_sub, out_in_n
  );
endinterface

// File: rtl/control_sequencer.sv
// SAP-style instruction register and fixed-length microcode step sequencer.
// Controls are decoded combinationally from the registered step and IR.
module control_sequencer #(
  parameter int unsigned STEP_COUNT = 5
) (
  input  logic               clk,
  input  logic               clr_n,
  control_sequencer_if.master cs
);

  typedef enum logic {
    S_RUN,
    S_HALTED
  } state_e;

  typedef enum logic [3:0] {
    OP_NOP = 4'h0,
    OP_LDA = 4'h1,
    OP_ADD = 4'h2,
    OP_SUB = 4'h3,
    OP_STA = 4'h4,
    OP_LDI = 4'h5,
    OP_JMP = 4'h6,
    OP_OUT = 4'hE,
    OP_HLT = 4'hF
  } opcode_e;

  localparam logic [2:0] LAST_STEP = 3'(STEP_COUNT - 1);

  state_e     state_q, state_d;
  logic [2:0] step_q, step_d;
  logic [7:0] ir_q, ir_d;
  logic       run;

  always_ff @(posedge clk) begin
    if (!clr_n) begin
      state_q <= S_RUN;
      step_q  <= '0;
      ir_q    <= '0;
    end else begin
      state_q <= state_d;
      step_q  <= step_d;
      ir_q    <= ir_d;
    end
  end

  always_comb begin
    state_d = state_q;
    step_d  = step_q;
    ir_d    = ir_q;
    if (!cs.prog_mode) begin
      state_d = S_RUN;
      step_d  = '0;
      ir_d    = '0;
    end else if (state_q == S_RUN) begin
      if (step_q == 3'd1) ir_d = cs.bus_in;
      // HLT freezes on T2 instead of advancing, so step reads back as 2 while halted
      if (step_q == 3'd2 && ir_q[7:4] == OP_HLT) begin
        state_d = S_HALTED;
      end else begin
        step_d = (step_q == LAST_STEP) ? '0 : step_q + 3'd1;
      end
    end
  end

  assign run            = cs.prog_mode && (state_q == S_RUN);
  assign cs.operand_out = ir_q[3:0];
  assign cs.opcode      = ir_q[7:4];
  assign cs.step        = step_q;

  always_comb begin
    cs.hlt       = (state_q == S_HALTED);
    cs.pc_out_n  = 1'b1;
    cs.pc_inc    = 1'b0;
    cs.pc_jump_n = 1'b1;
    cs.mar_in_n  = 1'b1;
    cs.ram_out_n = 1'b1;
    cs.ram_in    = 1'b0;
    cs.ir_in_n   = 1'b1;
    cs.ir_out_n  = 1'b1;
    cs.a_in_n    = 1'b1;
    cs.a_out_n   = 1'b1;
    cs.b_in_n    = 1'b1;
    cs.alu_out_n = 1'b1;
    cs.alu_sub   = 1'b0;
    cs.out_in_n  = 1'b1;
    if (run) begin
      case (step_q)
        3'd0: begin
          cs.pc_out_n = 1'b0;
          cs.mar_in_n = 1'b0;
        end
        3'd1: begin
          cs.ram_out_n = 1'b0;
          cs.ir_in_n   = 1'b0;
          cs.pc_inc    = 1'b1;
        end
        3'd2: begin
          case (ir_q[7:4])
            OP_LDA, OP_ADD, OP_SUB, OP_STA: begin
              cs.ir_out_n = 1'b0;
              cs.mar_in_n = 1'b0;
            end
            OP_LDI: begin
              cs.ir_out_n = 1'b0;
              cs.a_in_n   = 1'b0;
            end
            OP_JMP: begin
              cs.ir_out_n  = 1'b0;
              cs.pc_jump_n = 1'b0;
            end
            OP_OUT: begin
              cs.a_out_n  = 1'b0;
              cs.out_in_n = 1'b0;
            end
            OP_HLT:  cs.hlt = 1'b1;
            default: ;
          endcase
        end
        3'd3: begin
          case (ir_q[7:4])
            OP_LDA: begin
              cs.ram_out_n = 1'b0;
              cs.a_in_n    = 1'b0;
            end
            OP_ADD, OP_SUB: begin
              cs.ram_out_n = 1'b0;
              cs.b_in_n    = 1'b0;
            end
            OP_STA: begin
              cs.a_out_n = 1'b0;
              cs.ram_in  = 1'b1;
            end
            default: ;
          endcase
        end
        3'd4: begin
          if (ir_q[7:4] == OP_ADD || ir_q[7:4] == OP_SUB) begin
            cs.alu_out_n = 1'b0;
            cs.a_in_n    = 1'b0;
            cs.alu_sub   = (ir_q[7:4] == OP_SUB);
          end
        end
        default: ;
      endcase
    end
  end

  a_single_bus_driver: assert property (@(posedge clk) disable iff (!clr_n)
    $countones({~cs.pc_out_n, ~cs.ram_out_n, ~cs.ir_out_n, ~cs.a_out_n, ~cs.alu_out_n}) <= 1);

endmodule

// File: tb/tb_control_sequencer.sv
// Bench for control_sequencer: a table-driven model of the microcode checked every cycle.
// It is supplemented by hand-computed literal checks for the directed scenarios.
module tb_control_sequencer;
  localparam int unsigned SC = 5;

  // active-sense mask bit positions
  localparam int B_PC_OUT = 0, B_PC_INC = 1, B_PC_JMP = 2, B_MAR_IN = 3, B_RAM_OUT = 4;
  localparam int B_RAM_IN = 5, B_IR_IN = 6, B_IR_OUT = 7, B_A_IN = 8, B_A_OUT = 9;
  localparam int B_B_IN = 10, B_ALU_OUT = 11, B_ALU_SUB = 12, B_OUT_IN = 13, B_HLT = 14;

  logic clk = 1'b0;
  logic clr_n;
  control_sequencer_if cs ();

  control_sequencer #(.STEP_COUNT(SC)) dut (.clk(clk), .clr_n(clr_n), .cs(cs));

  always #5 clk = ~clk;

  int checks = 0;
  int failures = 0;

  // model state
  bit         mvalid = 0;
  int         mstep;
  logic [7:0] mir;
  bit         mhalt;
  logic [14:0] tbl [16][5];

  function automatic logic [14:0] bitm(input int b);
    logic [14:0] m;
    m = '0;
    m[b] = 1'b1;
    return m;
  endfunction

  initial begin
    for (int o = 0; o < 16; o++) begin
      tbl[o][0] = bitm(B_PC_OUT) | bitm(B_MAR_IN);
      tbl[o][1] = bitm(B_RAM_OUT) | bitm(B_IR_IN) | bitm(B_PC_INC);
      tbl[o][2] = '0;
      tbl[o][3] = '0;
      tbl[o][4] = '0;
    end
    for (int o = 1; o <= 4; o++) tbl[o][2] = bitm(B_IR_OUT) | bitm(B_MAR_IN);
    tbl[1][3] = bitm(B_RAM_OUT) | bitm(B_A_IN);
    tbl[2][3] = bitm(B_RAM_OUT) | bitm(B_B_IN);
    tbl[3][3] = bitm(B_RAM_OUT) | bitm(B_B_IN);
    tbl[2][4] = bitm(B_ALU_OUT) | bitm(B_A_IN);
    tbl[3][4] = bitm(B_ALU_OUT) | bitm(B_A_IN) | bitm(B_ALU_SUB);
    tbl[4][3] = bitm(B_A_OUT) | bitm(B_RAM_IN);
    tbl[5][2] = bitm(B_IR_OUT) | bitm(B_A_IN);
    tbl[6][2] = bitm(B_IR_OUT) | bitm(B_PC_JMP);
    tbl[14][2] = bitm(B_A_OUT) | bitm(B_OUT_IN);
    tbl[15][2] = bitm(B_HLT);
  end

  function automatic logic [14:0] expected_mask();
    if (mhalt) return bitm(B_HLT);
    if (!cs.prog_mode) return '0;
    if (mstep >= 5) return '0;
    return tbl[mir[7:4]][mstep];
  endfunction

  function automatic logic [14:0] dut_mask();
    return {cs.hlt, ~cs.out_in_n, cs.alu_sub, ~cs.alu_out_n, ~cs.b_in_n, ~cs.a_out_n,
            ~cs.a_in_n, ~cs.ir_out_n, ~cs.ir_in_n, cs.ram_in, ~cs.ram_out_n,
            ~cs.mar_in_n, ~cs.pc_jump_n, cs.pc_inc, ~cs.pc_out_n};
  endfunction

  always @(posedge clk) begin
    if (!clr_n || !cs.prog_mode) begin
      mstep = 0;
      mir   = 8'h00;
      mhalt = 0;
      if (!clr_n) mvalid = 1;
    end else if (!mhalt) begin
      if (mstep == 1) mir = cs.bus_in;
      if (mstep == 2 && mir[7:4] == 4'hF) mhalt = 1;
      else mstep = (mstep + 1) % SC;
    end
  end

  always @(negedge clk) begin
    if (mvalid) begin
      logic [14:0] d, e;
      d = dut_mask();
      e = expected_mask();
      checks++;
      if (int'(cs.step) != mstep) begin
        failures++;
        $display("FAIL model_step t=%0t got=%0d exp=%0d", $time, cs.step, mstep);
      end
      checks++;
      if ({cs.opcode, cs.operand_out} != mir) begin
        failures++;
        $display("FAIL model_ir t=%0t got=%h exp=%h", $time, {cs.opcode, cs.operand_out}, mir);
      end
      checks++;
      if (d !== e) begin
        failures++;
        $display("FAIL model_ctrl t=%0t got=%b exp=%b", $time, d, e);
      end
      checks++;
      if ($countones({d[B_PC_OUT], d[B_RAM_OUT], d[B_IR_OUT], d[B_A_OUT], d[B_ALU_OUT]}) > 1) begin
        failures++;
        $display("FAIL bus_contention t=%0t got=%b exp=at_most_one", $time, d);
      end
    end
  end

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s got=%0h exp=%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(negedge clk);
    #1;
  endtask

  initial begin
    clr_n = 1'b0;
    cs.prog_mode = 1'b1;
    cs.bus_in = 8'h00;
    tick();
    tick();
    chk("reset_step", int'(cs.step), 0);
    chk("reset_hlt", int'(cs.hlt), 0);
    chk("reset_t0_pc_out_n", int'(cs.pc_out_n), 0);
    chk("reset_t0_mar_in_n", int'(cs.mar_in_n), 0);
    clr_n = 1'b1;

    // LDA 0xE
    cs.bus_in = 8'h1E;
    tick();
    chk("lda_t1_step", int'(cs.step), 1);
    chk("lda_t1_ram_out_n", int'(cs.ram_out_n), 0);
    tick();
    chk("lda_t2_step", int'(cs.step), 2);
    chk("lda_opcode", int'(cs.opcode), 1);
    chk("lda_operand", int'(cs.operand_out), 14);
    chk("lda_t2_ir_out_n", int'(cs.ir_out_n), 0);
    chk("lda_t2_mar_in_n", int'(cs.mar_in_n), 0);
    tick();
    chk("lda_t3_ram_out_n", int'(cs.ram_out_n), 0);
    chk("lda_t3_a_in_n", int'(cs.a_in_n), 0);
    tick();
    chk("lda_t4_step", int'(cs.step), 4);
    tick();
    chk("lda_wrap_step", int'(cs.step), 0);

    // SUB
    cs.bus_in = 8'h3F;
    tick(); tick(); tick(); tick();
    chk("sub_t4_alu_out_n", int'(cs.alu_out_n), 0);
    chk("sub_t4_a_in_n", int'(cs.a_in_n), 0);
    chk("sub_t4_alu_sub", int'(cs.alu_sub), 1);
    tick();

    // STA
    cs.bus_in = 8'h4D;
    tick(); tick(); tick();
    chk("sta_t3_ram_in", int'(cs.ram_in), 1);
    chk("sta_t3_a_out_n", int'(cs.a_out_n), 0);
    tick();
    chk("sta_t4_ram_in", int'(cs.ram_in), 0);
    tick();

    // HLT
    cs.bus_in = 8'hF0;
    tick(); tick();
    chk("hlt_t2_hlt", int'(cs.hlt), 1);
    chk("hlt_t2_step", int'(cs.step), 2);
    repeat (20) tick();
    chk("hlt_hold_step", int'(cs.step), 2);
    chk("hlt_hold_hlt", int'(cs.hlt), 1);
    chk("hlt_hold_pc_out_n", int'(cs.pc_out_n), 1);
    clr_n = 1'b0;
    tick();
    clr_n = 1'b1;
    chk("hlt_clr_step", int'(cs.step), 0);
    chk("hlt_clr_hlt", int'(cs.hlt), 0);

    // ADD interrupted by program mode at T3
    cs.bus_in = 8'h2A;
    tick(); tick(); tick();
    chk("add_t3_step", int'(cs.step), 3);
    cs.prog_mode = 1'b0;
    tick();
    chk("prog_step", int'(cs.step), 0);
    chk("prog_opcode", int'(cs.opcode), 0);
    chk("prog_pc_out_n", int'(cs.pc_out_n), 1);
    chk("prog_ram_out_n", int'(cs.ram_out_n), 1);
    tick();
    cs.prog_mode = 1'b1;
    #1;
    chk("resume_pc_out_n", int'(cs.pc_out_n), 0);
    chk("resume_mar_in_n", int'(cs.mar_in_n), 0);

    // unassigned opcode
    cs.bus_in = 8'h95;
    tick(); tick();
    chk("nop9_opcode", int'(cs.opcode), 9);
    chk("nop9_t2_ir_out_n", int'(cs.ir_out_n), 1);
    tick(); tick(); tick();

    // random opcodes, HLT excluded so the run keeps going
    for (int i = 0; i < 1000; i++) begin
      cs.bus_in = {4'($urandom_range(0, 14)), 4'($urandom_range(0, 15))};
      cs.prog_mode = ($urandom_range(0, 49) != 0);
      tick();
    end

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end
endmodule

// File: doc/control_sequencer.md
Name: control_sequencer

Overview:
- Instruction register plus microcode step sequencer for the SAP-style CPU.
- Captures the opcode/operand byte that RAM drives onto the bus during fetch.
- Drives the RAM/MAR control strobes (MAR load, RAM out, RAM write) and the PC/A/B/ALU/OUT strobes.
- Sits directly downstream of the RAM data output and upstream of the RAM control inputs.

Parameters:
- STEP_COUNT, 5, number of microcode steps per instruction; legal range 5..8; steps T5 and above issue no control.

Ports:
- clk  in  1  system clock; all state updates on posedge.
- clr_n  in  1  synchronous active-low reset.
- prog_mode  in  1  1 = run (bus-driven RAM), 0 = program (dipswitch); 0 holds the sequencer idle.
- bus_in  in  8  system bus; IR loads from here.
- operand_out  out  4  IR[3:0], value driven onto bus[3:0] when ir_out_n = 0.
- opcode  out  4  IR[7:4].
- step  out  3  current T-state.
- hlt  out  1  halted flag, active high.
- pc_out_n  out  1  PC to bus.
- pc_inc  out  1  PC count enable.
- pc_jump_n  out  1  PC load from bus.
- mar_in_n  out  1  MAR load; feeds load_mar_reg_n.
- ram_out_n  out  1  RAM to bus; feeds bus_enable_n.
- ram_in  out  1  RAM write request; feeds control_signal.
- ir_in_n  out  1  IR load (observability).
- ir_out_n  out  1  IR operand to bus.
- a_in_n  out  1  A register load.
- a_out_n  out  1  A register to bus.
- b_in_n  out  1  B register load.
- alu_out_n  out  1  ALU result to bus.
- alu_sub  out  1  ALU subtract select.
- out_in_n  out  1  output register load.

Behaviour:
- Reset (clr_n = 0 at posedge): step = 0, IR = 8'h00, halted = 0.
  - Reset has priority over everything, including mid-instruction and while halted.
  - After the reset cycle all control outputs take their T0 values, or their idle values if prog_mode = 0.
- Idle values: every _n output = 1; pc_inc, ram_in, alu_sub, hlt = 0.
- prog_mode = 0: step forced to 0 and IR forced to 0 at each posedge; all controls idle.
  - When prog_mode returns to 1, the first cycle is T0.
- State:
  - step counter advances on posedge, 0 → STEP_COUNT−1, then wraps to 0. Fixed length; no early termination.
  - Halted: step and IR freeze; all controls idle; hlt = 1.
- Controls are decoded combinationally from registered step and IR, so they are stable for the full cycle and sampled by consumers at the next posedge.
- IR loads bus_in on the posedge that ends T1.
- Fetch (all opcodes):
  - T0: pc_out_n, mar_in_n.
  - T1: ram_out_n, ir_in_n, pc_inc.
- Execute steps by opcode (T2 / T3 / T4):
  - 0 NOP: none.
  - 1 LDA: ir_out_n+mar_in_n / ram_out_n+a_in_n / none.
  - 2 ADD: ir_out_n+mar_in_n / ram_out_n+b_in_n / alu_out_n+a_in_n.
  - 3 SUB: as ADD, with alu_sub = 1 during T4 only.
  - 4 STA: ir_out_n+mar_in_n / a_out_n+ram_in / none.
  - 5 LDI: ir_out_n+a_in_n at T2.
  - 6 JMP: ir_out_n+pc_jump_n at T2.
  - E OUT: a_out_n+out_in_n at T2.
  - F HLT: hlt asserted combinationally at T2; halted flag set at the posedge ending T2.
  - 7–D: treated as NOP.
- Bus contention: at most one *_out_n low in any cycle. This is guaranteed by the table; verify with an assertion.
- operand_out = IR[3:0] at all times; tri-state gating is external.

Test Plan:
- Reset, prog_mode = 1, bus_in = 8'h1E at T1 → step sequence 0,1,2,3,4,0; opcode = 1, operand_out = E; T2 asserts ir_out_n and mar_in_n low; T3 asserts ram_out_n and a_in_n low.
- bus_in = 8'h3F at T1 → T4 asserts alu_out_n = 0, a_in_n = 0, alu_sub = 1; alu_sub = 0 in every other step.
- bus_in = 8'h4D at T1 → ram_in = 1 only in T3, together with a_out_n = 0; ram_in = 0 in all other cycles.
- bus_in = 8'hF0 at T1 → hlt = 1 from T2 onward; step stays 2; controls idle for 20 cycles; clr_n = 0 for one cycle → step = 0, hlt = 0.
- prog_mode dropped to 0 at step 3 of ADD → next cycle step = 0, IR = 0, all controls idle; prog_mode = 1 → T0 fetch (pc_out_n = 0, mar_in_n = 0).
- Opcode 8'h9x and randomized opcodes over 1000 cycles → no cycle has two *_out_n signals low; 7–D produce only fetch controls.
